// File: rtl/int_mac_pkg.sv
// Shared constants for the integer MAC processing element and its local RAM.
package int_mac_pkg;

  localparam int MAC_LATENCY    = 3;
  localparam int DATA_W_DEF     = 32;
  localparam int L_RAM_SIZE_DEF = 4;

  // Signed-add overflow: the operands have the same sign and the sum's sign differs from it.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pe_local_ram.sv
// Single-port read-first local operand RAM with a registered output, 1 cycle read latency.
// Contents are deliberately not reset so the array maps onto block RAM.
module pe_local_ram
  import int_mac_pkg::*;
#(
  parameter int ADDR_W = L_RAM_SIZE_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-first: dout captures the old word even when the same address is written.
  always_ff @(posedge aclk) begin
    dout <= mem[addr];
    if (we) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/int_mac_pe.sv
// Integer MAC PE: acc += ain * local[addr]; 3-cycle latency, dvalid marks each completed MAC.
// Accepts a request every cycle and never stalls; reset flushes in-flight requests but not the RAM.
module int_mac_pe
  import int_mac_pkg::*;
#(
  parameter int L_RAM_SIZE = L_RAM_SIZE_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_W-1:0]     ain,
  input  logic [DATA_W-1:0]     din,
  input  logic [L_RAM_SIZE-1:0] addr,
  input  logic                  we,
  input  logic                  valid,
  output logic                  dvalid,
  output logic [DATA_W-1:0]     dout,
  output logic                  ovf
);

  logic [MAC_LATENCY-1:0] vld_sr;
  logic [DATA_W-1:0]      ram_q;
  logic [DATA_W-1:0]      ain_q;
  logic [DATA_W-1:0]      prod_q;
  logic [DATA_W-1:0]      acc;
  logic [DATA_W-1:0]      sum;
  logic                   sum_ovf;

  pe_local_ram #(
    .ADDR_W (L_RAM_SIZE),
    .DATA_W (DATA_W)
  ) u_ram (
    .aclk (aclk),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (ram_q)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[MAC_LATENCY-2:0], valid};
    end
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  // The low DATA_W bits of a DATA_W x DATA_W multiply equal the truncated full signed product.
  always_ff @(posedge aclk) begin
    ain_q  <= ain;
    prod_q <= $signed(ain_q) * $signed(ram_q);
  end

  assign sum     = acc + prod_q;
  assign sum_ovf = add_ovf(acc[DATA_W-1], prod_q[DATA_W-1], sum[DATA_W-1]);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (vld_sr[MAC_LATENCY-2]) begin
      acc <= sum;
      if (sum_ovf) begin
        ovf <= 1'b1;
      end
    end
  end

  assign dvalid = vld_sr[MAC_LATENCY-1];
  assign dout   = acc;

endmodule

// File: doc/int_mac_pe.md
INT_MAC_PE -- requirements
Module: int_mac_pe

Interface
REQ-001 The block SHALL have parameter L_RAM_SIZE, default 4, meaning log2 of local-RAM depth (16 words).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the operand and accumulator width.
REQ-003 aclk  input  1  clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 ain  input  DATA_W  streamed signed operand A.
REQ-006 din  input  DATA_W  signed operand B written into local RAM.
REQ-007 addr  input  L_RAM_SIZE  local-RAM address for both write and MAC read.
REQ-008 we  input  1  local-RAM write enable.
REQ-009 valid  input  1  MAC request: ain x local[addr].
REQ-010 dvalid  output  1  one-cycle pulse per completed MAC.
REQ-011 dout  output  DATA_W  current accumulator value.
REQ-012 ovf  output  1  sticky signed-overflow flag.

Function
REQ-013 The local RAM SHALL hold 2^L_RAM_SIZE words of DATA_W bits and write din to local[addr] on a cycle with we=1.
REQ-014 The local RAM SHALL be read-first: a read issued in the same cycle as a write to the same address SHALL return the old contents.
REQ-015 The MAC pipeline SHALL have three stages: S1 RAM read with ain registered; S2 product registered; S3 accumulate.
REQ-016 dvalid SHALL assert exactly 3 cycles after the cycle in which valid=1 is sampled, for one cycle per request.
REQ-017 Back-to-back valid SHALL be accepted every cycle with no stall and no dropped request: N requests produce N dvalid pulses.
REQ-018 The product SHALL be the full 2*DATA_W signed product, truncated to its low DATA_W bits before accumulation.
REQ-019 Accumulation SHALL be signed DATA_W two's-complement wrap-around: acc <= acc + prod.
REQ-020 dout SHALL show the updated accumulator in the same cycle that dvalid is high, and SHALL hold that value until the next accumulate.
REQ-021 ovf SHALL set when acc and prod have equal signs and the sum's sign differs; it SHALL remain set until reset.
REQ-022 A request with we=1 and valid=1 in the same cycle SHALL perform both operations; the MAC uses the pre-write RAM value.
REQ-023 valid=0 cycles SHALL insert bubbles: the accumulator and dvalid are unaffected by them.
REQ-024 Pipeline occupancy SHALL be tracked by a 3-bit valid shift register; no other state machine is required.

Reset
REQ-025 While aresetn=0 at a clock edge: acc=0, dout=0, dvalid=0, ovf=0, and all pipeline valid bits=0.
REQ-026 Reset SHALL NOT clear local-RAM contents, because the RAM is inferred as block RAM.
REQ-027 A reset asserted mid-pipeline SHALL discard in-flight requests: no dvalid is produced for them after reset releases.
REQ-028 The first valid accepted on the cycle after reset releases SHALL accumulate from 0.

Structure
REQ-029 A shared package int_mac_pkg SHALL hold MAC_LATENCY=3, the default DATA_W, and the default L_RAM_SIZE.
REQ-030 The local RAM SHALL be the sub-module pe_local_ram: single port, read-first, ram_style block, registered output.
REQ-031 All other logic (pipeline registers, multiplier, accumulator, overflow detection) SHALL reside in int_mac_pe.

Verification
REQ-032 Load local[0..15]=1..16; stream ain=1 with addr=0..15 over 16 consecutive valid cycles -> 16 dvalid pulses; final dout=136; ovf=0.
REQ-033 valid at cycle T with local[3]=5 and ain=-7 -> dvalid only at T+3; dout=-35 from T+3; no dvalid at T+1 or T+2.
REQ-034 In one cycle write din=9 to addr 2 (old value 4) with valid=1 and ain=2 at addr 2 -> accumulates 8, not 18.
REQ-035 acc=0x7FFFFFF0, then product 0x20 -> dout=0x80000010 and ovf=1; ovf stays 1 after a further product of -0x20.
REQ-036 Issue 3 valids, assert aresetn=0 for one cycle before the first dvalid -> no dvalid appears; dout=0; RAM contents unchanged.
REQ-037 Alternate valid 1/0 over 8 cycles with ain=local=2 -> 4 dvalid pulses spaced 2 cycles apart; dout=16.
